// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and a constant-width helper for the LED pattern generator.
package led_pattern_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period/duty/phase state, registered LED drive and
// the one-cycle ONESHOT completion pulse.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int               CNT_W      = 16,
  parameter logic [1:0]       RST_MODE   = MODE_OFF,
  parameter logic [CNT_W-1:0] RST_PERIOD = '0,
  parameter logic [CNT_W-1:0] RST_DUTY   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_lk,
  input  logic             i_tick,
  input  logic             i_we,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_led,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_phase;
  logic             r_led;
  logic             r_done;

  logic [1:0]       w_mode_next;
  logic [CNT_W-1:0] w_period_next;
  logic [CNT_W-1:0] w_duty_next;
  logic [CNT_W-1:0] w_phase_next;
  logic             w_finish;
  logic             w_led_next;

  // A write wins over everything, including a coincident tick.
  always_comb begin
    w_mode_next   = r_mode;
    w_period_next = r_period;
    w_duty_next   = r_duty;
    w_phase_next  = r_phase;
    w_finish      = 1'b0;
    if (i_we) begin
      w_mode_next   = i_mode;
      w_period_next = i_period;
      w_duty_next   = i_duty;
      w_phase_next  = '0;
    end else if (!i_lk) begin
      w_phase_next = '0;
    end else begin
      case (r_mode)
        MODE_BLINK: begin
          if (i_tick) begin
            if ((r_period == '0) || (r_phase >= (r_period - ONE))) w_phase_next = '0;
            else w_phase_next = r_phase + ONE;
          end
        end
        MODE_ONESHOT: begin
          // phase < duty here, so the increment can never wrap.
          if (r_phase >= r_duty) begin
            w_finish = 1'b1;
          end else if (i_tick) begin
            w_phase_next = r_phase + ONE;
            if (w_phase_next == r_duty) w_finish = 1'b1;
          end
          if (w_finish) w_mode_next = MODE_OFF;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_led_next = 1'b0;
    case (r_mode)
      MODE_ON:      w_led_next = 1'b1;
      MODE_BLINK:   w_led_next = (r_period != '0) && ((r_duty >= r_period) || (r_phase < r_duty));
      MODE_ONESHOT: w_led_next = (r_phase < r_duty);
      default:      w_led_next = 1'b0;
    endcase
    if (!i_lk || w_finish) w_led_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= RST_MODE;
      r_period <= RST_PERIOD;
      r_duty   <= RST_DUTY;
      r_phase  <= '0;
      r_led    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_mode   <= w_mode_next;
      r_period <= w_period_next;
      r_duty   <= w_duty_next;
      r_phase  <= w_phase_next;
      r_led    <= w_led_next;
      r_done   <= w_finish;
    end
  end

  assign o_led  = r_led;
  assign o_done = r_done;

endmodule

// File: rtl/led_pattern_gen.sv
// N-channel LED pattern generator: lock synchroniser, shared tick prescaler and
// config write decode feeding one led_channel per lamp.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int  N_CH       = 4,
  parameter int  CLK_HZ     = 16368000,
  parameter int  TICK_HZ    = 1000,
  parameter int  CNT_W      = 16,
  parameter int  DEF_PERIOD = 1000,
  parameter int  DEF_DUTY   = 500,
  localparam int CH_W       = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic [N_CH-1:0]  led,
  output logic             tick,
  output logic [N_CH-1:0]  oneshot_done
);

  localparam int             DIV      = CLK_HZ / TICK_HZ;
  localparam int             PRE_W    = clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic             r_lk_meta;
  logic             r_lk_s;
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  logic [N_CH-1:0]  w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
      r_pre     <= '0;
    end else begin
      r_lk_meta <= locked;
      r_lk_s    <= r_lk_meta;
      if (!r_lk_s || (r_pre == PRE_LAST)) r_pre <= '0;
      else r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_tick = r_lk_s && (r_pre == PRE_LAST);
  assign tick   = w_tick;

  // Channel 0 wakes up as the heartbeat; the rest come up dark.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    led_channel #(
      .CNT_W      (CNT_W),
      .RST_MODE   ((gi == 0) ? MODE_BLINK : MODE_OFF),
      .RST_PERIOD (CNT_W'((gi == 0) ? DEF_PERIOD : 0)),
      .RST_DUTY   (CNT_W'((gi == 0) ? DEF_DUTY : 0))
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_lk     (r_lk_s),
      .i_tick   (w_tick),
      .i_we     (w_we[gi]),
      .i_mode   (cfg_mode),
      .i_period (cfg_period),
      .i_duty   (cfg_duty),
      .o_led    (led[gi]),
      .o_done   (oneshot_done[gi])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: stimulus queues expected LED/done changes and tick edges,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         locked = 1'b1;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [1:0]   cfg_mode = '0;
  logic [15:0]  cfg_period = '0;
  logic [15:0]  cfg_duty = '0;
  logic [N-1:0] led;
  logic         tick;
  logic [N-1:0] oneshot_done;

  typedef struct {
    int           e;
    logic [N-1:0] l;
    logic [N-1:0] d;
  } ev_t;

  ev_t evq[$];
  int  tq[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  edge_n = 0;
  logic [N-1:0] prev_led = '0;
  logic [N-1:0] prev_done = '0;

  led_pattern_gen #(
    .N_CH(N), .CLK_HZ(100), .TICK_HZ(10), .CNT_W(16), .DEF_PERIOD(1000), .DEF_DUTY(500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led(led), .tick(tick), .oneshot_done(oneshot_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every change of led/oneshot_done is one transaction.
  always @(negedge clk) begin
    ev_t ex;
    int  te;
    if (led !== prev_led || oneshot_done !== prev_done) begin
      n_tests++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event edge=%0d led=%b done=%b", edge_n, led, oneshot_done);
      end else begin
        ex = evq.pop_front();
        if (ex.e != edge_n || ex.l !== led || ex.d !== oneshot_done) begin
          n_fail++;
          $display("FAIL event got edge=%0d led=%b done=%b required edge=%0d led=%b done=%b",
                   edge_n, led, oneshot_done, ex.e, ex.l, ex.d);
        end else begin
          $display("[TB] event edge=%0d led=%b done=%b ok", edge_n, led, oneshot_done);
        end
      end
      prev_led  = led;
      prev_done = oneshot_done;
    end
    if (tick === 1'b1 && tq.size() > 0) begin
      n_tests++;
      te = tq.pop_front();
      if (te != edge_n) begin
        n_fail++;
        $display("FAIL tick got edge=%0d required edge=%0d", edge_n, te);
      end else begin
        $display("[TB] tick edge=%0d ok", edge_n);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic push(input int e, input logic [N-1:0] l, input logic [N-1:0] d);
    ev_t x;
    x.e = e;
    x.l = l;
    x.d = d;
    evq.push_back(x);
  endtask

  // Drive at a negedge; the write lands on the following posedge.
  task automatic cfg_write(input int ch, input logic [1:0] m, input int p, input int d);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = m;
    cfg_period = 16'(p);
    cfg_duty   = 16'(d);
    @(negedge clk);
    cfg_we     = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int r;
    repeat (2) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_done", int'(oneshot_done), 0);

    // Heartbeat after reset release: 5000 clks on, 5000 off.
    b = edge_n;
    push(b + 3, 3'b001, 3'b000);
    push(b + 5003, 3'b000, 3'b000);
    push(b + 10003, 3'b001, 3'b000);
    tq.push_back(b + 11);
    tq.push_back(b + 21);
    tq.push_back(b + 31);
    rst_n = 1'b1;

    // ch1 BLINK 4/1, then period 0 while lit.
    wait_edge(b + 10004);
    push(b + 10006, 3'b011, 3'b000);
    push(b + 10013, 3'b001, 3'b000);
    push(b + 10043, 3'b011, 3'b000);
    push(b + 10053, 3'b001, 3'b000);
    push(b + 10083, 3'b011, 3'b000);
    push(b + 10091, 3'b001, 3'b000);
    cfg_write(1, MODE_BLINK, 4, 1);
    wait_edge(b + 10089);
    cfg_write(1, MODE_BLINK, 0, 1);

    // ch2 ONESHOT duty 3, then duty 0.
    wait_edge(b + 10104);
    push(b + 10106, 3'b101, 3'b000);
    push(b + 10132, 3'b001, 3'b100);
    push(b + 10133, 3'b001, 3'b000);
    cfg_write(2, MODE_ONESHOT, 0, 3);
    wait_edge(b + 10149);
    push(b + 10151, 3'b001, 3'b100);
    push(b + 10152, 3'b001, 3'b000);
    cfg_write(2, MODE_ONESHOT, 0, 0);

    // ch2 ONESHOT duty 2 restarted mid-run: single done, pushed out by the restart.
    wait_edge(b + 10164);
    push(b + 10166, 3'b101, 3'b000);
    push(b + 10192, 3'b001, 3'b100);
    push(b + 10193, 3'b001, 3'b000);
    cfg_write(2, MODE_ONESHOT, 0, 2);
    wait_edge(b + 10174);
    cfg_write(2, MODE_ONESHOT, 0, 2);

    // Write coincident with a tick restarts ch1 at phase 0; then OFF; then out-of-range channel.
    wait_edge(b + 10201);
    push(b + 10203, 3'b011, 3'b000);
    push(b + 10213, 3'b001, 3'b000);
    push(b + 10223, 3'b011, 3'b000);
    push(b + 10226, 3'b001, 3'b000);
    cfg_write(1, MODE_BLINK, 2, 1);
    wait_edge(b + 10224);
    cfg_write(1, MODE_OFF, 0, 0);
    wait_edge(b + 10229);
    cfg_write(3, MODE_ONESHOT, 0, 5);

    // ch0 fast blink 4/2, lock dropped for 50 clks, resumes from phase 0.
    wait_edge(b + 10234);
    push(b + 10253, 3'b000, 3'b000);
    push(b + 10273, 3'b001, 3'b000);
    push(b + 10288, 3'b000, 3'b000);
    push(b + 10338, 3'b001, 3'b000);
    push(b + 10358, 3'b000, 3'b000);
    push(b + 10378, 3'b001, 3'b000);
    cfg_write(0, MODE_BLINK, 4, 2);
    wait_edge(b + 10285);
    tq.push_back(b + 10346);
    tq.push_back(b + 10356);
    locked = 1'b0;
    wait_edge(b + 10335);
    locked = 1'b1;

    // Async reset in the middle of a ONESHOT.
    wait_edge(b + 10384);
    push(b + 10386, 3'b101, 3'b000);
    push(b + 10391, 3'b000, 3'b000);
    cfg_write(2, MODE_ONESHOT, 0, 3);
    wait_edge(b + 10390);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_done", int'(oneshot_done), 0);
    check("async_rst_tick", int'(tick), 0);
    wait_edge(b + 10395);
    r = edge_n;
    push(r + 3, 3'b001, 3'b000);
    tq.push_back(r + 11);
    tq.push_back(r + 21);
    rst_n = 1'b1;
    wait_edge(r + 30);

    check("events_left", evq.size(), 0);
    check("ticks_left", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
